// File: rtl/vga_timing_if.sv
// Raster timing bundle between vga_timing (master) and the renderer/DAC side (slave).
interface vga_timing_if;
  logic [11:0] rgb_in;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        p_tick;
  logic        frame_tick;
  logic        video_on;
  logic        hsync;
  logic        vsync;
  logic [11:0] vga_rgb;

  modport master (
    input  rgb_in,
    output x, y, p_tick, frame_tick, video_on, hsync, vsync, vga_rgb
  );

  modport slave (
    output rgb_in,
    input  x, y, p_tick, frame_tick, video_on, hsync, vsync, vga_rgb
  );
endinterface

// File: rtl/vga_timing.sv
// VGA raster timing: pixel enable, h/v counters, syncs and blanked colour register.
// Define VGA_SYNC_DELAY_EN to delay syncs one pixel so they line up with vga_rgb.
module vga_timing #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master vga
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div;
  logic [9:0]       h, v, h_next, v_next;
  logic             p_tick, video_on;
  logic             hsync_q, vsync_q;
  logic [11:0]      rgb_q;

  assign p_tick   = (div == DIV_MAX);
  assign video_on = (h < H_VIS) && (v < V_VIS);

  always_comb begin
    h_next = h + 10'd1;
    v_next = v;
    if (h == H_MAX) begin
      h_next = '0;
      v_next = (v == V_MAX) ? '0 : v + 10'd1;
    end
  end

  // Syncs are decoded from the next counter values so they change with x/y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div     <= '0;
      h       <= '0;
      v       <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= 12'h000;
    end else begin
      div <= p_tick ? '0 : div + DIV_W'(1);
      if (p_tick) begin
        h       <= h_next;
        v       <= v_next;
        hsync_q <= !((h_next >= HS_START) && (h_next <= HS_END));
        vsync_q <= !((v_next >= VS_START) && (v_next <= VS_END));
        rgb_q   <= video_on ? vga.rgb_in : 12'h000;
      end
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic hsync_d, vsync_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_d <= 1'b1;
      vsync_d <= 1'b1;
    end else if (p_tick) begin
      hsync_d <= hsync_q;
      vsync_d <= vsync_q;
    end
  end

  assign vga.hsync = hsync_d;
  assign vga.vsync = vsync_d;
`else
  assign vga.hsync = hsync_q;
  assign vga.vsync = vsync_q;
`endif

  assign vga.x          = h;
  assign vga.y          = v;
  assign vga.p_tick     = p_tick;
  assign vga.video_on   = video_on;
  assign vga.frame_tick = p_tick && (h == 10'd0) && (v == V_VIS);
  assign vga.vga_rgb    = rgb_q;
endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: default-size instance for line timing, shrunken instance for frame behaviour.
module tb_vga_timing;
  logic clk;
  logic rst_d, rst_s;
  int   n_chk, n_bad;

  vga_timing_if bus_d ();
  vga_timing_if bus_s ();

  vga_timing u_def (.clk(clk), .rst(rst_d), .vga(bus_d));

  // Small raster: 15 x 8 total, 8 x 4 visible, hsync at x 10..12, vsync at y 5..6.
  vga_timing #(
    .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_sml (.clk(clk), .rst(rst_s), .vga(bus_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

`ifdef VGA_SYNC_DELAY_EN
  localparam int SYNC_LAG = 1;
`else
  localparam int SYNC_LAG = 0;
`endif

  int   hs_fall_x, hs_rise_x, hs_low, wraps, y_err, x_max, xp_d, yp_d;
  logic hs_prev;
  int   e, sx, sy, pxv, pyv, hx, vy, nx, ny, sx_last, sy_last;
  int   err_pt, err_ft, err_vis, err_hs, err_vs, err_rgb, err_seq;
  int   ft_cnt, ft_last, ft_int_err, white, white_frame, wraps00, found;

  initial begin
    n_chk = 0; n_bad = 0;
    rst_d = 1'b1; rst_s = 1'b1;
    bus_d.rgb_in = 12'hFFF;
    bus_s.rgb_in = 12'hFFF;
    repeat (5) @(posedge clk);
    @(negedge clk);

    chk("rst_x",        int'(bus_d.x), 0);
    chk("rst_y",        int'(bus_d.y), 0);
    chk("rst_p_tick",   int'(bus_d.p_tick), 0);
    chk("rst_frame",    int'(bus_d.frame_tick), 0);
    chk("rst_video_on", int'(bus_d.video_on), 1);
    chk("rst_hsync",    int'(bus_d.hsync), 1);
    chk("rst_vsync",    int'(bus_d.vsync), 1);
    chk("rst_rgb",      int'(bus_d.vga_rgb), 0);

    rst_d = 1'b0; rst_s = 1'b0;
    repeat (3) @(negedge clk);
    chk("first_ptick", int'(bus_d.p_tick), 1);
    chk("first_x0",    int'(bus_d.x), 0);
    @(negedge clk);
    chk("first_x1",    int'(bus_d.x), 1);
    chk("ptick_drop",  int'(bus_d.p_tick), 0);

    hs_fall_x = -1; hs_rise_x = -1; hs_low = 0; wraps = 0; y_err = 0; x_max = 0;
    hs_prev = 1'b1; xp_d = 1; yp_d = 0;
    err_pt = 0; err_ft = 0; err_vis = 0; err_hs = 0; err_vs = 0; err_rgb = 0; err_seq = 0;
    ft_cnt = 0; ft_last = 0; ft_int_err = 0; white = 0; white_frame = -1; wraps00 = 0;
    sx_last = 2; sy_last = 0;

    for (int i = 0; i < 6400; i++) begin
      @(negedge clk);
      e = i + 5;

      if (bus_d.hsync != hs_prev) begin
        if (!bus_d.hsync && hs_fall_x < 0) hs_fall_x = int'(bus_d.x);
        if (bus_d.hsync && hs_rise_x < 0)  hs_rise_x = int'(bus_d.x);
      end
      hs_prev = bus_d.hsync;
      if (bus_d.p_tick && !bus_d.hsync) hs_low++;
      if (int'(bus_d.x) > x_max) x_max = int'(bus_d.x);
      if (xp_d == 799 && int'(bus_d.x) == 0) begin
        wraps++;
        if (int'(bus_d.y) != yp_d + 1) y_err++;
      end
      xp_d = int'(bus_d.x); yp_d = int'(bus_d.y);

      sx  = int'(bus_s.x); sy = int'(bus_s.y);
      pxv = (sx == 0) ? 14 : sx - 1;
      pyv = (sx == 0) ? ((sy == 0) ? 7 : sy - 1) : sy;
      hx  = (SYNC_LAG == 1) ? pxv : sx;
      vy  = (SYNC_LAG == 1) ? pyv : sy;
      if (bus_s.hsync !== !(hx >= 10 && hx <= 12)) err_hs++;
      if (bus_s.vsync !== !(vy >= 5 && vy <= 6)) err_vs++;
      if (bus_s.video_on !== (sx < 8 && sy < 4)) err_vis++;
      if (bus_s.vga_rgb !== ((pxv < 8 && pyv < 4) ? 12'hFFF : 12'h000)) err_rgb++;
      if (bus_s.p_tick !== (e % 2 == 1)) err_pt++;
      if (bus_s.frame_tick !== ((e % 2 == 1) && sx == 0 && sy == 4)) err_ft++;
      if (bus_s.frame_tick) begin
        ft_cnt++;
        if (ft_cnt > 1 && e - ft_last != 240) ft_int_err++;
        ft_last = e;
        if (ft_cnt == 2) white_frame = white;
        white = 0;
      end
      if (e % 2 == 1 && bus_s.vga_rgb == 12'hFFF) white++;
      if (sx != sx_last || sy != sy_last) begin
        nx = (sx_last == 14) ? 0 : sx_last + 1;
        ny = (sx_last == 14) ? ((sy_last == 7) ? 0 : sy_last + 1) : sy_last;
        if (sx != nx || sy != ny || e % 2 == 1) err_seq++;
        if (sx_last == 14 && sy_last == 7) wraps00++;
      end
      sx_last = sx; sy_last = sy;
    end

    chk("hs_fall_x",  hs_fall_x, 656 + SYNC_LAG);
    chk("hs_rise_x",  hs_rise_x, 752 + SYNC_LAG);
    chk("hs_low_pix", hs_low, 192);
    chk("line_wraps", wraps, 2);
    chk("y_inc_err",  y_err, 0);
    chk("x_max",      x_max, 799);
    chk("y_end",      int'(bus_d.y), 2);

    chk("s_ptick_err", err_pt, 0);
    chk("s_frame_err", err_ft, 0);
    chk("s_vis_err",   err_vis, 0);
    chk("s_hsync_err", err_hs, 0);
    chk("s_vsync_err", err_vs, 0);
    chk("s_rgb_err",   err_rgb, 0);
    chk("s_seq_err",   err_seq, 0);
    chk("s_frames",    ft_cnt, 27);
    chk("s_ft_period", ft_int_err, 0);
    chk("s_white",     white_frame, 32);
    chk("s_wrap00",    wraps00, 26);

    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      @(negedge clk);
      if (int'(bus_s.x) == 5 && int'(bus_s.y) == 3) found = 1;
    end
    chk("mid_wait", found, 1);
    if (found == 1) begin
      chk("mid_rgb_pre", int'(bus_s.vga_rgb), 12'hFFF);
      #2 rst_s = 1'b1;
      #1;
      chk("mid_x",     int'(bus_s.x), 0);
      chk("mid_y",     int'(bus_s.y), 0);
      chk("mid_hsync", int'(bus_s.hsync), 1);
      chk("mid_vsync", int'(bus_s.vsync), 1);
      chk("mid_rgb",   int'(bus_s.vga_rgb), 0);
      chk("mid_ptick", int'(bus_s.p_tick), 0);
      @(negedge clk);
      rst_s = 1'b0;
      @(negedge clk);
      chk("mid_first_ptick", int'(bus_s.p_tick), 1);
      chk("mid_first_x",     int'(bus_s.x), 0);
      @(negedge clk);
      chk("mid_x1", int'(bus_s.x), 1);
      chk("mid_y0", int'(bus_s.y), 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
